// File: rtl/prelude_sequencer.sv
// Prelude load/run sequencer: streams a program into the 256x8 program RAM,
// holds the core in reset while loading, then gates the core clock enable
// for run, halt, single-step and PC-breakpoint debugging.
module prelude_sequencer #(
  parameter int RESET_HOLD = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic [7:0]       load_len,
  input  logic             load_abort,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  output logic             load_ready,
  output logic             prog_we,
  output logic [7:0]       prog_addr,
  output logic [7:0]       prog_wdata,
  input  logic             cmd_run,
  input  logic             cmd_halt,
  input  logic             cmd_step,
  input  logic             bp_en,
  input  logic [7:0]       bp_addr,
  input  logic [7:0]       cpu_pc,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             bp_hit,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] run_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_HALT    = 3'd3,
    ST_RUN     = 3'd4,
    ST_STEP    = 3'd5
  } state_t;

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  state_t            cur_state;
  state_t            next_state;
  logic [7:0]        addr_q;
  logic [8:0]        remaining_q;
  logic [HOLD_W-1:0] hold_q;
  logic              first_run_q;
  logic              bp_hit_q;
  logic [CNT_W-1:0]  run_cycles_q;

  logic byte_take;
  logic bp_fire;
  logic load_enter;
  logic clear_bp;
  logic core_active;

  // Next-state decode and the combinational core/RAM control outputs
  always_comb begin
    next_state = cur_state;
    load_ready = 1'b0;
    cpu_reset  = 1'b1;
    cpu_en     = 1'b0;
    byte_take  = 1'b0;
    bp_fire    = 1'b0;
    load_enter = 1'b0;
    clear_bp   = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (load_start) begin
          next_state = ST_LOAD;
          load_enter = 1'b1;
        end
      end
      ST_LOAD: begin
        load_ready = ~reset;
        if (load_abort) begin
          next_state = ST_IDLE;
        end else if (load_valid && !reset) begin
          byte_take = 1'b1;
          if (remaining_q == 9'd1) begin
            next_state = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        cpu_en = 1'b1;
        if (hold_q == HOLD_LAST) begin
          next_state = ST_HALT;
        end
      end
      ST_HALT: begin
        cpu_reset = 1'b0;
        if (load_start) begin
          next_state = ST_LOAD;
          load_enter = 1'b1;
        end else if (cmd_halt) begin
          next_state = ST_HALT;
        end else if (cmd_step) begin
          next_state = ST_STEP;
          clear_bp   = 1'b1;
        end else if (cmd_run) begin
          next_state = ST_RUN;
          clear_bp   = 1'b1;
        end
      end
      ST_STEP: begin
        cpu_reset  = 1'b0;
        cpu_en     = 1'b1;
        next_state = ST_HALT;
      end
      ST_RUN: begin
        cpu_reset = 1'b0;
        bp_fire   = bp_en && (cpu_pc == bp_addr) && !first_run_q;
        cpu_en    = !(bp_fire || cmd_halt);
        if (bp_fire || cmd_halt) begin
          next_state = ST_HALT;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign prog_we     = byte_take;
  assign prog_addr   = addr_q;
  assign prog_wdata  = load_data;
  assign bp_hit      = bp_hit_q;
  assign state       = cur_state;
  assign run_cycles  = run_cycles_q;
  assign core_active = cpu_en && !cpu_reset;

  // State register; first_run_q marks the first RUN cycle after a HALT
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= ST_IDLE;
      first_run_q <= 1'b0;
    end else begin
      cur_state   <= next_state;
      first_run_q <= (cur_state == ST_HALT);
    end
  end

  // Load address and remaining-byte counters; a length of 0 means a full 256
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= 8'd0;
      remaining_q <= 9'd0;
    end else if (load_enter) begin
      addr_q      <= 8'd0;
      remaining_q <= (load_len == 8'd0) ? 9'd256 : {1'b0, load_len};
    end else if (byte_take) begin
      addr_q      <= addr_q + 8'd1;
      remaining_q <= remaining_q - 9'd1;
    end
  end

  // Counts the cycles spent in RELEASE so the core reset is held long enough
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else if (cur_state == ST_RELEASE) begin
      hold_q <= hold_q + 1'b1;
    end else begin
      hold_q <= '0;
    end
  end

  // Sticky breakpoint flag, cleared by a new load or by resuming from HALT
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_hit_q <= 1'b0;
    end else if (load_enter || clear_bp) begin
      bp_hit_q <= 1'b0;
    end else if (bp_fire) begin
      bp_hit_q <= 1'b1;
    end
  end

  // Retired-cycle counter: every cycle the core is enabled and out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles_q <= '0;
    end else if (load_enter) begin
      run_cycles_q <= '0;
    end else if (core_active) begin
      run_cycles_q <= run_cycles_q + 1'b1;
    end
  end

endmodule
